// File: rtl/chroma_key_mixer_if.sv
// chroma_key_mixer_if: pixel, keying config and frame status bundle for chroma_key_mixer
interface chroma_key_mixer_if #(
   parameter int COLOR_W = 10,
   parameter int CNT_W = 20
);
   logic [COLOR_W-1:0] iFG_R, iFG_G, iFG_B;
   logic [COLOR_W-1:0] iBG_R, iBG_G, iBG_B;
   logic iFG_VALID, iFG_SOF;
   logic [1:0] iMODE;
   logic [COLOR_W-1:0] iKEY_MIN, iMARGIN;
   logic iSPILL_EN;
   logic [COLOR_W-1:0] oR, oG, oB;
   logic oVALID, oSOF, oKEY, oFRAME_DONE;
   logic [CNT_W-1:0] oKEY_COUNT;
   modport master (
      output iFG_R, iFG_G, iFG_B, iBG_R, iBG_G, iBG_B, iFG_VALID, iFG_SOF,
      output iMODE, iKEY_MIN, iMARGIN, iSPILL_EN,
      input oR, oG, oB, oVALID, oSOF, oKEY, oKEY_COUNT, oFRAME_DONE
   );
   modport slave (
      input iFG_R, iFG_G, iFG_B, iBG_R, iBG_G, iBG_B, iFG_VALID, iFG_SOF,
      input iMODE, iKEY_MIN, iMARGIN, iSPILL_EN,
      output oR, oG, oB, oVALID, oSOF, oKEY, oKEY_COUNT, oFRAME_DONE
   );
endinterface

// File: rtl/chroma_key_mixer.sv
// chroma_key_mixer: 3-stage green/blue-screen compositor with per-frame config shadowing and keyed-pixel count
module chroma_key_mixer #(
   parameter int COLOR_W = 10,
   parameter int CNT_W = 20
) (
   input logic iCLK,
   input logic iRST,
   chroma_key_mixer_if.slave bus
);
   typedef logic [COLOR_W-1:0] chanT;
   logic [1:0] modeSh, modeCur;
   chanT keyMinSh, marginSh, keyMinCur, marginCur;
   logic spillSh, spillCur, sofIn;
   logic s1Valid, s1Sof, s1Spill;
   logic [1:0] s1Mode;
   chanT s1FgR, s1FgG, s1FgB, s1BgR, s1BgG, s1BgB, s1KeyMin, s1Margin;
   chanT s1K, s1O2, s1M;
   logic [COLOR_W:0] s1D;
   logic s1Key, s1SpillHit;
   logic s2Valid, s2Sof, s2Key, s2SpillHit;
   logic [1:0] s2Mode;
   chanT s2FgR, s2FgG, s2FgB, s2BgR, s2BgG, s2BgB, s2M;
   logic [3*COLOR_W-1:0] nPix, outPix;
   logic outValid, outSof, outKey, frameDone, firstSeen;
   logic [CNT_W-1:0] runCnt, keyCount;
   // the SOF pixel itself must already see the freshly loaded config
   assign sofIn = bus.iFG_VALID & bus.iFG_SOF;
   assign modeCur = sofIn ? bus.iMODE : modeSh;
   assign keyMinCur = sofIn ? bus.iKEY_MIN : keyMinSh;
   assign marginCur = sofIn ? bus.iMARGIN : marginSh;
   assign spillCur = sofIn ? bus.iSPILL_EN : spillSh;
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         modeSh <= '0;
         keyMinSh <= '0;
         marginSh <= '0;
         spillSh <= 1'b0;
         s1Valid <= 1'b0;
         s1Sof <= 1'b0;
      end else begin
         modeSh <= modeCur;
         keyMinSh <= keyMinCur;
         marginSh <= marginCur;
         spillSh <= spillCur;
         s1Valid <= bus.iFG_VALID;
         s1Sof <= sofIn;
      end
   end
   always_ff @(posedge iCLK) begin
      if (bus.iFG_VALID) begin
         {s1FgR, s1FgG, s1FgB} <= {bus.iFG_R, bus.iFG_G, bus.iFG_B};
         {s1BgR, s1BgG, s1BgB} <= {bus.iBG_R, bus.iBG_G, bus.iBG_B};
         s1Mode <= modeCur;
         s1KeyMin <= keyMinCur;
         s1Margin <= marginCur;
         s1Spill <= spillCur;
      end
   end
   assign s1K = s1Mode == 2'd2 ? s1FgB : s1FgG;
   assign s1O2 = s1Mode == 2'd2 ? s1FgG : s1FgB;
   assign s1M = s1FgR > s1O2 ? s1FgR : s1O2;
   assign s1D = {1'b0, s1K} - {1'b0, s1M};
   assign s1Key = (s1Mode != 2'd0) & (s1K >= s1KeyMin) & ($signed(s1D) > $signed({1'b0, s1Margin}));
   assign s1SpillHit = s1Spill & (s1Mode == 2'd1 | s1Mode == 2'd2) & (s1K > s1M);
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         s2Valid <= 1'b0;
         s2Sof <= 1'b0;
      end else begin
         s2Valid <= s1Valid;
         s2Sof <= s1Sof;
      end
   end
   always_ff @(posedge iCLK) begin
      if (s1Valid) begin
         {s2FgR, s2FgG, s2FgB} <= {s1FgR, s1FgG, s1FgB};
         {s2BgR, s2BgG, s2BgB} <= {s1BgR, s1BgG, s1BgB};
         s2Mode <= s1Mode;
         s2Key <= s1Key;
         s2SpillHit <= s1SpillHit;
         s2M <= s1M;
      end
   end
   always_comb begin
      nPix = {s2FgR, (s2SpillHit & ~s2Mode[1]) ? s2M : s2FgG, (s2SpillHit & s2Mode[1]) ? s2M : s2FgB};
      nPix = s2Key ? {s2BgR, s2BgG, s2BgB} : nPix;
      nPix = s2Mode == 2'd3 ? {3*COLOR_W{s2Key}} : nPix;
   end
   // counting runs on the pixel entering the output register so the status lines up with oSOF
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         outPix <= '0;
         outValid <= 1'b0;
         outSof <= 1'b0;
         outKey <= 1'b0;
         frameDone <= 1'b0;
         firstSeen <= 1'b0;
         runCnt <= '0;
         keyCount <= '0;
      end else begin
         outValid <= s2Valid;
         outSof <= s2Sof;
         frameDone <= s2Valid & s2Sof & firstSeen;
         if (s2Valid) begin
            outPix <= nPix;
            outKey <= s2Key;
            if (s2Sof) begin
               keyCount <= firstSeen ? runCnt : keyCount;
               runCnt <= CNT_W'(s2Key);
               firstSeen <= 1'b1;
            end else begin
               runCnt <= &runCnt ? runCnt : runCnt + CNT_W'(s2Key);
            end
         end
      end
   end
   assign {bus.oR, bus.oG, bus.oB} = outPix;
   assign bus.oVALID = outValid;
   assign bus.oSOF = outSof;
   assign bus.oKEY = outKey;
   assign bus.oKEY_COUNT = keyCount;
   assign bus.oFRAME_DONE = frameDone;
endmodule

// File: tb/tb_chroma_key_mixer.sv
// tb_chroma_key_mixer: directed vectors into a scoreboard queue, checked by an independent output monitor
module tb_chroma_key_mixer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int passed = 0;
   int total = 0;
   logic eDone = 1'b0;
   logic [19:0] eCnt = '0;
   logic [3:0] eCnt4 = '0;
   typedef struct {
      logic [9:0] r, g, b;
      logic key, sof, done;
      logic [19:0] cnt;
      logic [3:0] cnt4;
      int cyc;
   } expT;
   expT q[$];
   chroma_key_mixer_if #(.COLOR_W(10), .CNT_W(20)) bus ();
   chroma_key_mixer_if #(.COLOR_W(10), .CNT_W(4)) bus4 ();
   chroma_key_mixer #(.COLOR_W(10), .CNT_W(20)) dut (.iCLK(clk), .iRST(rst), .bus(bus.slave));
   chroma_key_mixer #(.COLOR_W(10), .CNT_W(4)) dut4 (.iCLK(clk), .iRST(rst), .bus(bus4.slave));
   assign bus4.iFG_R = bus.iFG_R;
   assign bus4.iFG_G = bus.iFG_G;
   assign bus4.iFG_B = bus.iFG_B;
   assign bus4.iBG_R = bus.iBG_R;
   assign bus4.iBG_G = bus.iBG_G;
   assign bus4.iBG_B = bus.iBG_B;
   assign bus4.iFG_VALID = bus.iFG_VALID;
   assign bus4.iFG_SOF = bus.iFG_SOF;
   assign bus4.iMODE = bus.iMODE;
   assign bus4.iKEY_MIN = bus.iKEY_MIN;
   assign bus4.iMARGIN = bus.iMARGIN;
   assign bus4.iSPILL_EN = bus.iSPILL_EN;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0d, want %0d", name, act, want);
   endtask
   task automatic chkRst(input string tag);
      chk({tag, "_valid"}, 32'(bus.oVALID), 0);
      chk({tag, "_count"}, 32'(bus.oKEY_COUNT), 0);
      chk({tag, "_rgb"}, {2'b0, bus.oR, bus.oG, bus.oB}, 0);
   endtask
   task automatic pix(input logic sof, input int fr, fg, fb, br, bg, bb, er, eg, eb, input logic ek);
      expT e;
      bus.iFG_VALID = 1'b1;
      bus.iFG_SOF = sof;
      {bus.iFG_R, bus.iFG_G, bus.iFG_B} = {10'(fr), 10'(fg), 10'(fb)};
      {bus.iBG_R, bus.iBG_G, bus.iBG_B} = {10'(br), 10'(bg), 10'(bb)};
      e.r = 10'(er);
      e.g = 10'(eg);
      e.b = 10'(eb);
      e.key = ek;
      e.sof = sof;
      e.done = eDone;
      e.cnt = eCnt;
      e.cnt4 = eCnt4;
      e.cyc = cyc + 3;
      q.push_back(e);
      eDone = 1'b0;
      @(negedge clk);
   endtask
   // bubbles carry a stray SOF and junk data, both of which must be ignored
   task automatic idle();
      bus.iFG_VALID = 1'b0;
      bus.iFG_SOF = 1'b1;
      {bus.iFG_R, bus.iFG_G, bus.iFG_B} = 30'($urandom);
      {bus.iBG_R, bus.iBG_G, bus.iBG_B} = 30'($urandom);
      @(negedge clk);
   endtask
   task automatic frameStart(input logic done, input int cnt, input int cnt4);
      eDone = done;
      eCnt = 20'(cnt);
      eCnt4 = 4'(cnt4);
   endtask
   always @(negedge clk) begin : monitor
      expT e;
      if (!rst) begin
         if (bus.oVALID) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_output: got oVALID=1, want no pending pixel");
            end else begin
               e = q.pop_front();
               chk("pixel", {2'b0, bus.oR, bus.oG, bus.oB}, {2'b0, e.r, e.g, e.b});
               chk("key", 32'(bus.oKEY), 32'(e.key));
               chk("sof", 32'(bus.oSOF), 32'(e.sof));
               chk("latency", cyc, e.cyc);
               chk("frame_done", 32'(bus.oFRAME_DONE), 32'(e.done));
               chk("key_count", 32'(bus.oKEY_COUNT), 32'(e.cnt));
               chk("key_count_w4", 32'(bus4.oKEY_COUNT), 32'(e.cnt4));
            end
         end else begin
            chk("done_on_bubble", 32'(bus.oFRAME_DONE), 0);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end
   initial begin
      bus.iMODE = 2'd1;
      bus.iKEY_MIN = 10'd256;
      bus.iMARGIN = 10'd64;
      bus.iSPILL_EN = 1'b0;
      bus.iFG_VALID = 1'b1;
      bus.iFG_SOF = 1'b1;
      {bus.iFG_R, bus.iFG_G, bus.iFG_B} = {10'd100, 10'd800, 10'd120};
      {bus.iBG_R, bus.iBG_G, bus.iBG_B} = {10'd5, 10'd6, 10'd7};
      @(negedge clk);
      chkRst("rst1");
      @(negedge clk);
      chkRst("rst2");
      rst = 1'b0;
      frameStart(0, 0, 0);
      pix(1, 100, 800, 120, 5, 6, 7, 5, 6, 7, 1);
      chkRst("post_rst");
      pix(0, 100, 150, 120, 1, 2, 3, 100, 150, 120, 0);
      pix(0, 100, 420, 356, 1, 2, 3, 100, 420, 356, 0);
      pix(0, 0, 256, 0, 9, 9, 9, 9, 9, 9, 1);
      bus.iMODE = 2'd0;
      bus.iSPILL_EN = 1'b1;
      pix(0, 100, 800, 120, 5, 6, 7, 5, 6, 7, 1);
      pix(0, 100, 150, 120, 1, 2, 3, 100, 150, 120, 0);
      bus.iMODE = 2'd1;
      frameStart(1, 3, 3);
      pix(1, 100, 150, 120, 1, 2, 3, 100, 120, 120, 0);
      bus.iMODE = 2'd3;
      idle();
      pix(0, 100, 800, 120, 5, 6, 7, 5, 6, 7, 1);
      pix(0, 300, 200, 100, 1, 2, 3, 300, 200, 100, 0);
      idle();
      idle();
      pix(0, 0, 256, 0, 1, 1, 1, 1, 1, 1, 1);
      pix(0, 100, 420, 356, 1, 2, 3, 100, 356, 356, 0);
      idle();
      pix(0, 10, 20, 900, 1, 2, 3, 10, 20, 900, 0);
      pix(0, 200, 900, 100, 2, 3, 4, 2, 3, 4, 1);
      pix(0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0);
      bus.iMODE = 2'd2;
      bus.iSPILL_EN = 1'b0;
      frameStart(1, 3, 3);
      pix(1, 10, 20, 900, 7, 8, 9, 7, 8, 9, 1);
      pix(0, 100, 800, 120, 1, 1, 1, 100, 800, 120, 0);
      for (int i = 0; i < 19; i++) begin
         pix(0, 0, 0, 1000, 3, 3, 3, 3, 3, 3, 1);
         if (i % 5 == 4) idle();
      end
      bus.iMODE = 2'd3;
      frameStart(1, 20, 15);
      pix(1, 100, 800, 120, 5, 6, 7, 1023, 1023, 1023, 1);
      pix(0, 100, 150, 120, 5, 6, 7, 0, 0, 0, 0);
      pix(0, 10, 20, 900, 5, 6, 7, 0, 0, 0, 0);
      bus.iMODE = 2'd0;
      frameStart(1, 1, 1);
      pix(1, 100, 800, 120, 5, 6, 7, 100, 800, 120, 0);
      pix(0, 0, 256, 0, 5, 6, 7, 0, 256, 0, 0);
      bus.iMODE = 2'd1;
      pix(0, 100, 800, 120, 5, 6, 7, 100, 800, 120, 0);
      repeat (4) idle();
      rst = 1'b1;
      pix(0, 100, 800, 120, 5, 6, 7, 5, 6, 7, 1);
      void'(q.pop_back());
      chkRst("mid_rst");
      rst = 1'b0;
      frameStart(0, 0, 0);
      pix(1, 100, 800, 120, 5, 6, 7, 5, 6, 7, 1);
      pix(0, 0, 256, 0, 9, 9, 9, 9, 9, 9, 1);
      pix(0, 100, 150, 120, 1, 2, 3, 100, 150, 120, 0);
      bus.iSPILL_EN = 1'b1;
      frameStart(1, 2, 2);
      pix(1, 100, 150, 120, 1, 2, 3, 100, 120, 120, 0);
      repeat (5) idle();
      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: got %0d outputs missing, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/chroma_key_mixer.md
Name: chroma_key_mixer

Overview:
- Parametrised, pipelined green/blue-screen compositor between the RAW-to-RGB converter output and the VGA frame path.
- Per pixel, decides whether the camera (foreground) pixel matches the key colour, then substitutes the background pixel, passes the foreground with optional spill suppression, or outputs the matte.
- Keying config is shadowed at start-of-frame. Counts keyed pixels per frame for the HEX display.

Parameters:
- COLOR_W, 10, bits per colour channel.
- CNT_W, 20, width of per-frame keyed-pixel counter.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  synchronous reset, active-high.
- iFG_R, iFG_G, iFG_B  in  COLOR_W each  foreground pixel.
- iFG_VALID  in  1  pixel qualifier.
- iFG_SOF  in  1  first pixel of frame; only meaningful with iFG_VALID.
- iBG_R, iBG_G, iBG_B  in  COLOR_W each  background pixel, aligned with the foreground pixel.
- iMODE  in  2  0 bypass, 1 green key, 2 blue key, 3 matte (green key).
- iKEY_MIN  in  COLOR_W  minimum key-channel level.
- iMARGIN  in  COLOR_W  required key-channel excess over the other channels.
- iSPILL_EN  in  1  enable spill suppression.
- oR, oG, oB  out  COLOR_W each  composited pixel.
- oVALID  out  1  output qualifier.
- oSOF  out  1  delayed SOF.
- oKEY  out  1  pixel was keyed.
- oKEY_COUNT  out  CNT_W  keyed pixels in the last completed frame.
- oFRAME_DONE  out  1  one-cycle pulse when oKEY_COUNT updates.

Behaviour:
- Reset, synchronous while iRST=1: all outputs 0; pipeline valid/SOF bits 0; shadow regs MODE=0, KEY_MIN=0, MARGIN=0, SPILL=0; running counter 0; first-frame flag cleared.
- No backpressure. One pixel per cycle accepted when iFG_VALID=1.
- Invalid cycles propagate as bubbles: data regs hold, valid=0, no counting.
- Shadow config:
  - Loaded from iMODE/iKEY_MIN/iMARGIN/iSPILL_EN on the cycle iFG_VALID & iFG_SOF. That SOF pixel already uses the new values.
  - Config changes mid-frame have no effect until the next SOF.
  - iFG_SOF without iFG_VALID is ignored.
- Fixed 3-cycle latency, input to oVALID/oSOF/pixel.
- Stage 1 (registers FG, BG, valid, SOF):
  - Key channel K = G (modes 0/1/3) or B (mode 2).
  - Other channels O1, O2 = {R,B} or {R,G}.
  - M = max(O1,O2).
- Stage 2:
  - D = K − M, COLOR_W+1 bits signed.
  - key = (mode≠0) & (K ≥ KEY_MIN) & (D > MARGIN), zero-extended compare.
  - K == KEY_MIN qualifies. D == MARGIN does not qualify. D negative never keys.
- Stage 3 output mux:
  - mode 0: FG, oKEY=0.
  - modes 1/2, key=1: BG.
  - modes 1/2, key=0: FG. If SPILL=1 and K>M, the key channel is replaced by M; other channels unchanged.
  - mode 3: all channels all-ones if key, else all zeros.
  - oKEY=key.
- Counter, evaluated on stage-3 output pixels with oVALID=1:
  - If oSOF=1: oKEY_COUNT<=running count; running count<=oKEY. oFRAME_DONE pulses the same cycle, except for the first SOF after reset, which only sets the first-frame flag and clears/loads the counter.
  - Otherwise running count += oKEY, saturating at 2^CNT_W−1.
  - oKEY_COUNT holds between frames.
- Reset mid-frame: pipeline flushed, the partial frame is discarded, and no oFRAME_DONE is produced for it.

Test Plan:
- Reset: hold iRST 2 cycles while streaming valid pixels → oVALID=0, oKEY_COUNT=0, oR/G/B=0 during and 1 cycle after release; first output 3 cycles after the first accepted pixel.
- Green key, COLOR_W=10, SOF with mode=1, KEY_MIN=256, MARGIN=64, spill off; FG(100,800,120) with BG(5,6,7) → 3 cycles later out (5,6,7), oKEY=1.
- Green key, same config: FG(100,150,120) → out (100,150,120), oKEY=0. Same pixel with spill on → (100,120,120).
- Boundaries: FG(100,420,356) (D=64=MARGIN) → not keyed. FG(0,256,0) (K=KEY_MIN, D=256) → keyed. Blue mode: FG(10,20,900) → keyed.
- Mid-frame config: set iMODE=0 without SOF → green pixels remain keyed. Next SOF pixel → bypass, oKEY=0.
- Counting: frames of 8 valid pixels with bubbles interleaved, 3 keyed in frame 2 → at frame-3 SOF output, oKEY_COUNT=3, oFRAME_DONE high exactly 1 cycle; no pulse at the first SOF. With CNT_W=4 and 20 keyed pixels in a frame → oKEY_COUNT=15.
